// File: rtl/movegen_scheduler.sv
// movegen_scheduler: scans the 64 board squares in ascending order and hands each own piece to a shared
// move generator over a four-phase req/ack handshake. Optional gen_ack timeout under MOVEGEN_TIMEOUT_EN.
package movegen_pkg;
   typedef struct packed {
      logic       colour;  // 0 white, 1 black
      logic [2:0] kind;    // 0 = empty square
   } fullpiece_t;
endpackage

module movegen_scheduler
   import movegen_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              side,
   input  fullpiece_t [63:0] board,
   output logic              gen_req,
   output logic [2:0]        gen_kind,
   output logic [5:0]        gen_from,
   input  logic              gen_ack,
   input  logic              gen_valid,
   input  logic [5:0]        gen_position,
   output logic              move_valid,
   output logic [5:0]        move_from,
   output logic [5:0]        move_to,
   output logic              busy,
   output logic              done,
   output logic              err
);
   typedef enum logic [2:0] {IDLE, SCAN, REQ, RELEASE, FINISH} state_t;

   state_t     state_q, state_d;
   logic [5:0] sq_q, sq_d;
   logic       side_q, side_d;
   logic [2:0] gen_kind_q, gen_kind_d;
   logic [5:0] gen_from_q, gen_from_d;
   logic       move_valid_q;
   logic [5:0] move_from_q, move_to_q;
   logic       own_piece, in_hs, step, timeout;

   assign own_piece = (board[sq_q].kind != 3'd0) && (board[sq_q].colour == side_q);
   assign in_hs     = (state_q == REQ) || (state_q == RELEASE);

   always_comb begin
      state_d    = state_q;
      sq_d       = sq_q;
      side_d     = side_q;
      gen_kind_d = gen_kind_q;
      gen_from_d = gen_from_q;
      step       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               sq_d    = 6'd0;
               side_d  = side;
            end
         end
         SCAN: begin
            if (own_piece) begin
               state_d    = REQ;
               gen_from_d = sq_q;
               gen_kind_d = board[sq_q].kind;
            end else begin
               step = 1'b1;
            end
         end
         REQ: begin
            if (gen_ack) state_d = RELEASE;
            else if (timeout) step = 1'b1;
         end
         RELEASE: begin
            if (!gen_ack || timeout) step = 1'b1;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Square 63 ends the scan instead of wrapping back to 0.
      if (step) begin
         if (sq_q == 6'd63) begin
            state_d = FINISH;
         end else begin
            sq_d    = sq_q + 6'd1;
            state_d = SCAN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sq_q         <= 6'd0;
         side_q       <= 1'b0;
         gen_kind_q   <= 3'd0;
         gen_from_q   <= 6'd0;
         move_valid_q <= 1'b0;
         move_from_q  <= 6'd0;
         move_to_q    <= 6'd0;
      end else begin
         state_q      <= state_d;
         sq_q         <= sq_d;
         side_q       <= side_d;
         gen_kind_q   <= gen_kind_d;
         gen_from_q   <= gen_from_d;
         move_valid_q <= gen_valid && in_hs;
         if (gen_valid && in_hs) begin
            move_from_q <= gen_from_q;
            move_to_q   <= gen_position;
         end
      end
   end

`ifdef MOVEGEN_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_q;
   logic             err_q;

   // One budget covers the whole handshake, REQ and RELEASE together.
   assign timeout = in_hs && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign err     = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (in_hs && !timeout) wait_q <= wait_q + 1'b1;
         else                   wait_q <= '0;
         if ((state_q == IDLE) && start) err_q <= 1'b0;
         else if (timeout)               err_q <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   assign gen_req    = (state_q == REQ);
   assign gen_kind   = gen_kind_q;
   assign gen_from   = gen_from_q;
   assign move_valid = move_valid_q;
   assign move_from  = move_from_q;
   assign move_to    = move_to_q;
   assign busy       = (state_q == SCAN) || in_hs;
   assign done       = (state_q == FINISH);
endmodule

// File: tb/tb_movegen_scheduler.sv
// Randomised bench for movegen_scheduler: a behavioural generator responder plus a scan-order /
// cycle-count model, and a per-cycle compare process for the registered move output.
module tb_movegen_scheduler;
   import movegen_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              side = 1'b0;
   fullpiece_t [63:0] board = '0;
   logic              gen_req;
   logic [2:0]        gen_kind;
   logic [5:0]        gen_from;
   logic              gen_ack = 1'b0;
   logic              gen_valid = 1'b0;
   logic [5:0]        gen_position = 6'd0;
   logic              move_valid;
   logic [5:0]        move_from, move_to;
   logic              busy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   movegen_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .side(side), .board(board),
      .gen_req(gen_req), .gen_kind(gen_kind), .gen_from(gen_from),
      .gen_ack(gen_ack), .gen_valid(gen_valid), .gen_position(gen_position),
      .move_valid(move_valid), .move_from(move_from), .move_to(move_to),
      .busy(busy), .done(done), .err(err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Responder state shared with the compare process.
   bit         hs_now = 1'b0;
   logic [5:0] cur_from = 6'd0;
   int         mv_count = 0;
   int         served[$];

   bit         exp_mv = 1'b0;
   logic [5:0] exp_from, exp_to;

   // Any candidate offered during a handshake cycle must appear exactly one cycle later.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_mv = 1'b0;
      end else begin
         check("move_valid", move_valid, exp_mv);
         if (exp_mv) begin
            check("move_from", move_from, exp_from);
            check("move_to", move_to, exp_to);
         end
         if (move_valid) mv_count++;
         exp_mv   = gen_valid && hs_now;
         exp_from = cur_from;
         exp_to   = gen_position;
      end
   end

   // ack_min < 0 means the generator never acknowledges; cand_mode 0 random, 1 every
   // handshake cycle, 2 none. Returns the cycle (start cycle = 0) on which done was seen.
   task automatic run_scan(input int ack_min, input int ack_max, input int hold_min, input int hold_max,
                           input int cand_mode, input bit poke, input int limit,
                           output int done_at, output int cost, output logic err_at_done);
      int phase, a, h, cnt;
      served.delete();
      mv_count = 0;
      cost = 0; done_at = -1; err_at_done = 1'bx;
      phase = 0; a = 0; h = 0; cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= limit; cyc++) begin
         gen_valid = 1'b0;
         hs_now    = 1'b0;
         start     = poke && (cyc == 7);
         if (poke && cyc == 7) side = ~side;
         if (done) begin
            done_at     = cyc;
            err_at_done = err;
            check("busy_at_done", busy, 0);
            break;
         end
         check("busy_during_scan", busy, 1);
         hs_now = gen_req || (phase != 0);
         if (phase == 0 && gen_req) begin
            served.push_back(gen_from);
            cur_from = gen_from;
            check("gen_kind", gen_kind, board[gen_from].kind);
            a = (ack_min < 0) ? 32'h4000_0000 : $urandom_range(ack_max, ack_min);
            h = $urandom_range(hold_max, hold_min);
            cnt = 0; phase = 1;
            cost += a + 2 + h;
         end
         if (phase == 1) begin
            if (gen_req) check("gen_from_stable", gen_from, cur_from);
            if (cnt == a) begin gen_ack = 1'b1; phase = 2; cnt = 0; end
            else cnt++;
         end else if (phase == 2 && !gen_req) begin
            if (cnt == h) begin gen_ack = 1'b0; phase = 0; end
            else cnt++;
         end
         gen_position = 6'($urandom);
         if (cand_mode == 1)      gen_valid = hs_now;
         else if (cand_mode == 0) gen_valid = hs_now ? ($urandom_range(1, 0) == 1) : ($urandom_range(7, 0) == 0);
         @(posedge clk); #1;
      end
      gen_ack = 1'b0; gen_valid = 1'b0; hs_now = 1'b0; start = 1'b0;
   endtask

   task automatic check_served(input bit s);
      int exp_q[$];
      for (int i = 0; i < 64; i++)
         if (board[i].kind != 3'd0 && board[i].colour == s) exp_q.push_back(i);
      check("served_count", served.size(), exp_q.size());
      if (served.size() == exp_q.size())
         foreach (exp_q[i]) check("served_square", served[i], exp_q[i]);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_gen_req"}, gen_req, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_move_valid"}, move_valid, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      int         done_at, cost;
      logic       e;
      bit         s;

      // Reset state
      #2;
      check("rst_gen_kind", gen_kind, 0);
      check("rst_gen_from", gen_from, 0);
      check("rst_move_from", move_from, 0);
      check("rst_move_to", move_to, 0);
      check_idle_outputs("rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Empty board: 64 scan cycles plus FINISH
      side = 1'b0;
      run_scan(0, 3, 0, 2, 0, 1'b0, 200, done_at, cost, e);
      check("empty_done_cycle", done_at, 65);
      check("empty_served", served.size(), 0);
      check("empty_err", e, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_busy", busy, 0);

      // White king on 4, ack after 3 cycles, 5 candidates
      board = '0;
      board[4] = '{colour: 1'b0, kind: 3'd6};
      side = 1'b0;
      run_scan(3, 3, 0, 0, 1, 1'b0, 300, done_at, cost, e);
      @(posedge clk); #1;
      check("king_served_count", served.size(), 1);
      if (served.size() == 1) check("king_from", served[0], 4);
      check("king_moves", mv_count, 5);
      check("king_done_cycle", done_at, 70);

      // White on 0 and 63, black on 10
      board = '0;
      board[0]  = '{colour: 1'b0, kind: 3'd1};
      board[63] = '{colour: 1'b0, kind: 3'd4};
      board[10] = '{colour: 1'b1, kind: 3'd2};
      side = 1'b0;
      run_scan(0, 2, 0, 2, 0, 1'b0, 300, done_at, cost, e);
      check("edge_served_count", served.size(), 2);
      if (served.size() == 2) begin
         check("edge_first", served[0], 0);
         check("edge_last", served[1], 63);
      end
      check("edge_done_cycle", done_at, 65 + cost);
      @(posedge clk); #1;

      // Random boards; some with a start pulse and side flip mid-scan
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 64; i++) begin
            board[i].colour = 1'($urandom);
            board[i].kind   = ($urandom_range(3, 0) == 0) ? 3'($urandom_range(6, 1)) : 3'd0;
         end
         s = 1'($urandom);
         side = s;
         run_scan(0, 3, 0, 2, 0, (t % 2) == 1, 2000, done_at, cost, e);
         check_served(s);
         check("rand_done_cycle", done_at, 65 + cost);
         check("rand_err", e, 0);
         @(posedge clk); #1;
      end

      // Reset in the middle of a handshake
      board = '0;
      board[5] = '{colour: 1'b1, kind: 3'd3};
      side = 1'b1;
      run_scan(-1, 0, 0, 0, 2, 1'b0, 20, done_at, cost, e);
      check("pre_reset_gen_req", gen_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      check("midreset_gen_from", gen_from, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      board[0] = '{colour: 1'b1, kind: 3'd5};
      run_scan(0, 2, 0, 1, 0, 1'b0, 300, done_at, cost, e);
      check("post_reset_served_count", served.size(), 2);
      if (served.size() > 0) check("post_reset_first_sq", served[0], 0);
      check("post_reset_done_cycle", done_at, 65 + cost);
      @(posedge clk); #1;

      // Generator never acknowledges
      board = '0;
      board[2] = '{colour: 1'b0, kind: 3'd2};
      side = 1'b0;
`ifdef MOVEGEN_TIMEOUT_EN
      run_scan(-1, 0, 0, 0, 2, 1'b0, 600, done_at, cost, e);
      check("timeout_done_cycle", done_at, 65 + 255);
      check("timeout_err", e, 1);
      @(posedge clk); #1;
      check("err_sticky", err, 1);
      board = '0;
      run_scan(0, 0, 0, 0, 2, 1'b0, 200, done_at, cost, e);
      check("err_cleared", e, 0);
      check("after_timeout_done", done_at, 65);
`else
      run_scan(-1, 0, 0, 0, 2, 1'b0, 400, done_at, cost, e);
      check("noack_no_done", done_at, -1);
      check("noack_busy", busy, 1);
      check("noack_gen_req", gen_req, 1);
      check("noack_err", err, 0);
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
`endif
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
